// File: rtl/bdd_pkg.sv
// Shared types and constants for the BDD model loader: FSM states, field widths
// and the bytes-per-word figures for the RAM1/RAM2 node records.
package bdd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD1,
    ST_LOAD2,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam int CLASS_W  = 8;
  localparam int THRESH_W = 10;
  localparam int LINK_W   = 9;

  localparam int RAM1_W = 3 * CLASS_W + THRESH_W;
  localparam int RAM2_W = 2 * LINK_W;

  // Number of stream bytes needed to carry a word of the given width.
  function automatic int bytes_for(input int width);
    return (width + 7) / 8;
  endfunction

  localparam int B1 = (RAM1_W + 7) / 8;
  localparam int B2 = (RAM2_W + 7) / 8;

endpackage

// File: rtl/bdd_word_assembler.sv
// Byte-to-word assembler: little-endian byte lanes, a byte index counter and a
// word-complete pulse raised in the same cycle the final byte is accepted.
module bdd_word_assembler #(
  parameter int WORD_W = 34,
  parameter int NB     = (WORD_W + 7) / 8,
  parameter int KW     = $clog2(NB + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            byte_en,
  input  logic [7:0]      byte_in,
  input  logic [KW-1:0]   nbytes,
  output logic [NB*8-1:0] word,
  output logic            word_done
);

  logic [KW-1:0] k_reg;
  logic          last_byte;

  assign last_byte = byte_en && (k_reg == nbytes - KW'(1));
  assign word_done = last_byte;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_reg <= '0;
    end else if (clear) begin
      k_reg <= '0;
    end else if (byte_en) begin
      k_reg <= last_byte ? '0 : k_reg + KW'(1);
    end
  end

  // The current byte is forwarded into the word so the caller can register it
  // on the acceptance edge, giving a one-cycle write latency.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] lane_reg;
      logic       hit;

      assign hit = byte_en && (k_reg == KW'(gi));

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          lane_reg <= '0;
        end else if (hit) begin
          lane_reg <= byte_in;
        end
      end

      assign word[gi*8 +: 8] = hit ? byte_in : lane_reg;
    end
  endgenerate

endmodule

// File: rtl/bdd_model_loader.sv
// Byte-serial model image loader feeding the node RAM write ports.
// Optional trailing XOR checksum byte enabled by BDD_LOADER_CHECKSUM_EN.
module bdd_model_loader
  import bdd_pkg::*;
#(
  parameter int RAM1_DATA_WIDTH = 34,
  parameter int RAM2_DATA_WIDTH = 18,
  parameter int ADDR_WIDTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       restart,
  input  logic [7:0]                 s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic                       we1,
  output logic                       we2,
  output logic [ADDR_WIDTH-1:0]      in_addr,
  output logic [RAM1_DATA_WIDTH-1:0] ram1_data_in,
  output logic [RAM2_DATA_WIDTH-1:0] ram2_data_in,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int NB1  = bytes_for(RAM1_DATA_WIDTH);
  localparam int NB2  = bytes_for(RAM2_DATA_WIDTH);
  localparam int KW   = $clog2(NB1 + 1);
  localparam int NMAX = 1 << ADDR_WIDTH;

  state_t                     state_reg, state_next;
  logic [ADDR_WIDTH:0]        n_reg;
  logic [ADDR_WIDTH-1:0]      node_reg;
  logic [ADDR_WIDTH-1:0]      in_addr_reg;
  logic [RAM1_DATA_WIDTH-1:0] ram1_data_reg;
  logic [RAM2_DATA_WIDTH-1:0] ram2_data_reg;
  logic                       we1_reg, we2_reg, done_reg;

  logic            accept, load_byte, word_done, last_node, hdr_ok;
  logic [NB1*8-1:0] asm_word;
  logic [KW-1:0]   nbytes;

  assign s_ready   = (state_reg != ST_DONE) && (state_reg != ST_ERR);
  assign busy      = (state_reg == ST_LOAD1) || (state_reg == ST_LOAD2) ||
                     (state_reg == ST_CSUM);
  assign err       = (state_reg == ST_ERR);
  assign done      = done_reg;
  assign accept    = s_valid && s_ready;
  assign load_byte = accept && ((state_reg == ST_LOAD1) || (state_reg == ST_LOAD2));
  assign nbytes    = (state_reg == ST_LOAD2) ? KW'(NB2) : KW'(NB1);
  assign hdr_ok    = (s_data != 8'd0) && (32'(s_data) <= NMAX);
  assign last_node = ({1'b0, node_reg} == n_reg - 1'b1);

  assign we1          = we1_reg;
  assign we2          = we2_reg;
  assign in_addr      = in_addr_reg;
  assign ram1_data_in = ram1_data_reg;
  assign ram2_data_in = ram2_data_reg;

  bdd_word_assembler #(
    .WORD_W (RAM1_DATA_WIDTH)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (state_reg == ST_IDLE),
    .byte_en   (load_byte),
    .byte_in   (s_data),
    .nbytes    (nbytes),
    .word      (asm_word),
    .word_done (word_done)
  );

`ifdef BDD_LOADER_CHECKSUM_EN
  logic [7:0] csum_reg;

  // Running XOR over every accepted frame byte, header included.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum_reg <= '0;
    end else if (accept) begin
      csum_reg <= (state_reg == ST_IDLE) ? s_data : (csum_reg ^ s_data);
    end
  end
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) state_next = hdr_ok ? ST_LOAD1 : ST_ERR;
      end
      ST_LOAD1: begin
        if (word_done && last_node) state_next = ST_LOAD2;
      end
      ST_LOAD2: begin
`ifdef BDD_LOADER_CHECKSUM_EN
        if (word_done && last_node) state_next = ST_CSUM;
`else
        if (word_done && last_node) state_next = ST_DONE;
`endif
      end
`ifdef BDD_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (accept) state_next = (s_data == csum_reg) ? ST_DONE : ST_ERR;
      end
`endif
      ST_DONE: begin
        if (restart) state_next = ST_IDLE;
      end
      ST_ERR: begin
        if (restart) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      n_reg         <= '0;
      node_reg      <= '0;
      in_addr_reg   <= '0;
      ram1_data_reg <= '0;
      ram2_data_reg <= '0;
      we1_reg       <= 1'b0;
      we2_reg       <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      we1_reg   <= 1'b0;
      we2_reg   <= 1'b0;
      // done trails the final RAM2 strobe by one cycle and drops with restart.
      done_reg  <= (state_reg == ST_DONE) && !restart;

      if (state_reg == ST_IDLE) begin
        node_reg <= '0;
        if (accept) n_reg <= s_data[ADDR_WIDTH:0];
      end

      if (word_done) begin
        in_addr_reg <= node_reg;
        node_reg    <= last_node ? '0 : node_reg + 1'b1;
        if (state_reg == ST_LOAD1) begin
          we1_reg       <= 1'b1;
          ram1_data_reg <= asm_word[RAM1_DATA_WIDTH-1:0];
        end else begin
          we2_reg       <= 1'b1;
          ram2_data_reg <= asm_word[RAM2_DATA_WIDTH-1:0];
        end
      end
    end
  end

endmodule
